// File: rtl/colour_patch_reporter_pkg.sv
// Shared types and constants for the colour patch reporter.
// Colour codes, ASCII bytes, letter mapping and FSM states.
package colour_patch_reporter_pkg;

  localparam logic [2:0] WHITE = 3'b000;
  localparam logic [2:0] RED   = 3'b001;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b011;

  localparam logic [7:0] ASC_P  = 8'h50;
  localparam logic [7:0] ASC_R  = 8'h52;
  localparam logic [7:0] ASC_G  = 8'h47;
  localparam logic [7:0] ASC_B  = 8'h42;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RES,
    EVAL,
    SEND
  } state_e;

  function automatic logic [7:0] colour_letter(
    input logic [2:0] c
  );
    logic [7:0] l;
    case (c)
      RED:     l = ASC_R;
      GREEN:   l = ASC_G;
      BLUE:    l = ASC_B;
      default: l = 8'h3F;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/colour_patch_reporter_bin2ascii_2d.sv
// Binary count to two ASCII decimal digits.
// Purely combinational; counts stay below 100.
module bin2ascii_2d
  import colour_patch_reporter_pkg::*;
(
  input  logic [6:0] bin,
  output logic [7:0] tens_asc,
  output logic [7:0] ones_asc
);

  logic [6:0] tens;
  logic [6:0] ones;

  // split into tens and ones, then offset to ASCII
  always_comb begin
    tens     = bin / 7'd10;
    ones     = bin - 7'(tens * 7'd10);
    tens_asc = ASC_0 + {1'b0, tens};
    ones_asc = ASC_0 + {1'b0, ones};
  end

endmodule

// File: rtl/colour_patch_reporter.sv
// Debounces sensor colours and streams a 5-byte
// ASCII report for every newly reached patch.
module colour_patch_reporter
  import colour_patch_reporter_pkg::*;
#(
  parameter int CONFIRM   = 2,
  parameter int MAX_PATCH = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [2:0] color,
  input  logic       valid,
  output logic       measure,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [6:0] patch_count,
  output logic [2:0] last_colour,
  output logic       busy
);

  localparam logic [2:0] CONF_L = 3'(CONFIRM);
  localparam logic [6:0] MAXP_L = 7'(MAX_PATCH);

  state_e     state_q, state_d;
  logic [2:0] samp_q, samp_d;
  logic [2:0] cand_q, cand_d;
  logic [2:0] run_cnt_q, run_cnt_d;
  logic [2:0] last_q, last_d;
  logic       gap_q, gap_d;
  logic       armed_q, armed_d;
  logic       meas_q, meas_d;
  logic [6:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;

  logic       accept;
  logic       hs;
  logic [2:0] s_norm;
  logic [2:0] new_cand;
  logic [2:0] new_run;
  logic       confirm;
  logic       report;
  logic [7:0] tens_asc;
  logic [7:0] ones_asc;

  bin2ascii_2d u_digits (
    .bin      (cnt_q),
    .tens_asc (tens_asc),
    .ones_asc (ones_asc)
  );

  assign accept = (state_q == WAIT_RES) && run
               && valid && armed_q;
  assign hs     = (state_q == SEND) && tx_ready;

  // debounce update for the latched sample
  always_comb begin
    s_norm   = samp_q[2] ? WHITE : samp_q;
    new_cand = s_norm;
    new_run  = 3'd1;
    confirm  = (CONF_L == 3'd1);
    if (s_norm == cand_q) begin
      new_cand = cand_q;
      new_run  = (run_cnt_q < CONF_L)
               ? run_cnt_q + 3'd1 : CONF_L;
      confirm  = (run_cnt_q < CONF_L)
              && (run_cnt_q + 3'd1 == CONF_L);
    end
    report = confirm && (new_cand != WHITE)
          && (gap_q || (new_cand != last_q));
  end

  // next-state and bookkeeping
  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    cand_d    = cand_q;
    run_cnt_d = run_cnt_q;
    last_d    = last_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    meas_d    = 1'b0;
    armed_d   = armed_q;

    if (accept || meas_q) begin
      armed_d = 1'b0;
    end else if (!valid) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (run) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (!run) begin
          state_d = IDLE;
        end else if (accept) begin
          samp_d  = color;
          meas_d  = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        cand_d    = new_cand;
        run_cnt_d = new_run;
        state_d   = WAIT_RES;
        if (confirm && new_cand == WHITE) begin
          gap_d = 1'b1;
        end
        if (report) begin
          last_d  = new_cand;
          gap_d   = 1'b0;
          cnt_d   = (cnt_q == MAXP_L)
                  ? 7'd0 : cnt_q + 7'd1;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (idx_q == 3'd4) begin
            state_d = run ? WAIT_RES : IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
    endcase
  end

  // report byte for the current index
  always_comb begin
    tx_data = 8'h00;
    if (state_q == SEND) begin
      unique case (idx_q)
        3'd0:    tx_data = ASC_P;
        3'd1:    tx_data = tens_asc;
        3'd2:    tx_data = ones_asc;
        3'd3:    tx_data = colour_letter(last_q);
        default: tx_data = ASC_LF;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      samp_q    <= WHITE;
      cand_q    <= WHITE;
      run_cnt_q <= 3'd0;
      last_q    <= WHITE;
      gap_q     <= 1'b1;
      armed_q   <= 1'b1;
      meas_q    <= 1'b0;
      cnt_q     <= 7'd0;
      idx_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      cand_q    <= cand_d;
      run_cnt_q <= run_cnt_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      armed_q   <= armed_d;
      meas_q    <= meas_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
    end
  end

  assign measure     = meas_q;
  assign tx_valid    = (state_q == SEND);
  assign busy        = (state_q == SEND);
  assign patch_count = cnt_q;
  assign last_colour = last_q;

endmodule
